vctr_sq_accum: RTL
==================

// Module: vctr_sq_accum
// PURPOSE
//  Downstream consumer of the vector-add FIFO stage. On that stage's done pulse it
//  drains exactly VECTOR_LENGTH elements from the result FIFO, accumulates sum or
//  sum-of-squares (unsigned), and presents one scalar result with valid/ready
//  handshake. Result feeds the distance/score logic of the hyperspectral ID datapath.
// PARAMETERS
//  DATA_WIDTH     16  element width of upstream FIFO data_out
//  VECTOR_LENGTH  8   elements drained per transaction (= upstream FIFO depth)
//  ACC_WIDTH      2*DATA_WIDTH+$clog2(VECTOR_LENGTH)  accumulator/result width (derived localparam)
// PORTS
//  clk            in   1           clock, all logic on posedge
//  rst_n          in   1           asynchronous active-low reset
//  sq_en          in   1           1: accumulate x*x, 0: accumulate x; sampled on trigger
//  vctr_done      in   1           upstream done (high while its output FIFO is draining)
//  vctr_rd_en     out  1           upstream data_out_en / FIFO pop request
//  vctr_data      in   DATA_WIDTH  upstream data_out, valid 1 cycle after vctr_rd_en
//  result_data    out  ACC_WIDTH   accumulated result
//  result_valid   out  1           result_data valid; held until accepted
//  result_ready   in   1           downstream accept
//  busy           out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE; vctr_rd_en, result_valid, busy=0; result_data, acc, cnt, pipeline valids=0; done_q=0.
//  Trigger = vctr_done & ~done_q (rising edge; done_q resets 0, so done high at reset release triggers once).
//  FSM IDLE -> DRAIN -> FLUSH -> RESULT -> IDLE:
//   IDLE  : on trigger: acc<=0, cnt<=0, mode<=sq_en, -> DRAIN. Other inputs ignored.
//   DRAIN : vctr_rd_en=1 (combinational from state); cnt++ each cycle; at cnt==VECTOR_LENGTH-1 -> FLUSH.
//           Exactly VECTOR_LENGTH pops, one per cycle, no gaps.
//   FLUSH : vctr_rd_en=0; wait until both pipeline valids are 0 -> RESULT, result_data<=acc.
//   RESULT: result_valid=1, result_data stable; on result_ready -> IDLE (same edge drops valid).
//  Pipeline: s1: v1<=vctr_rd_en, d1<=vctr_data sampled in cycle after pop;
//            s2: if v1: acc += mode ? d1*d1 : d1 (zero-extended to ACC_WIDTH).
//  Latency: trigger edge -> result_valid = VECTOR_LENGTH + 3 cycles (no backpressure).
//  Width: ACC_WIDTH sized so all-ones input in square mode never overflows; no saturation.
//  Boundaries:
//   - vctr_done held high past transaction: no retrigger until it falls and rises again.
//   - trigger while busy: ignored (edge consumed, not queued).
//   - result_ready high while result_valid=0: no effect.
//   - result_ready low indefinitely: stay in RESULT, no further pops.
//   - rst_n asserted mid-DRAIN/FLUSH: immediate abort, all state cleared, no partial result;
//     upstream FIFO residue is the upstream block's concern.
//   - VECTOR_LENGTH==1: DRAIN lasts one cycle.
// STRUCTURE
//  hsid_vctr_pkg: acc_state_t enum {IDLE, DRAIN, FLUSH, RESULT}; ACC_WIDTH calc function.
//  Sub-module hsid_sq_acc_stage: s1/s2 pipeline (mode, clear, in_valid, data -> acc).
//  Top: FSM, cnt ($clog2(VECTOR_LENGTH) bits), edge detect, output register.
// TESTING (DATA_WIDTH=16, VECTOR_LENGTH=8, FIFO model with 1-cycle read latency)
//  1 FIFO 1..8, sq_en=1, ready=1 -> exactly 8 rd_en cycles; result 204, valid 1 cycle at trigger+11.
//  2 FIFO 1..8, sq_en=0 -> result 36; sq_en toggled mid-DRAIN has no effect.
//  3 FIFO 8x0xFFFF, sq_en=1 -> result 35'h7_FFF0_0008 (34358689800), no overflow.
//  4 ready low 5 cycles after valid -> valid/data stable 5 cycles, 0 pops, IDLE after accept.
//  5 done held high 30 cycles -> one transaction; drop then raise -> second, correct result.
//  6 rst_n low at 4th pop -> all outputs 0 next cycle; new trigger after release -> fresh correct result.

Source files
------------

// File: rtl/hsid_vctr_pkg.sv
// Shared types and width helpers for the vector square/sum accumulator.
package hsid_vctr_pkg;

  typedef logic [1:0] acc_state_t;

  localparam acc_state_t IDLE   = 2'd0;
  localparam acc_state_t DRAIN  = 2'd1;
  localparam acc_state_t FLUSH  = 2'd2;
  localparam acc_state_t RESULT = 2'd3;

  // Wide enough that VECTOR_LENGTH all-ones squares never overflow.
  function automatic int unsigned calc_acc_width(input int unsigned data_width,
                                                 input int unsigned vector_length);
    return 2 * data_width + $clog2(vector_length);
  endfunction

endpackage

// File: rtl/hsid_sq_acc_stage.sv
// Two-stage accumulate pipeline: FIFO data is captured one cycle after the pop request,
// then added (or squared and added) into the accumulator.
module hsid_sq_acc_stage #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 35
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_i,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic                  pipe_busy_o
);

  logic                    v0_q, v1_q;
  logic [DATA_WIDTH-1:0]   d1_q;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [2*DATA_WIDTH-1:0] d_ext, addend;

  always_comb begin
    d_ext  = {{DATA_WIDTH{1'b0}}, d1_q};
    addend = mode_i ? d_ext * d_ext : d_ext;
    acc_d  = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (v1_q) begin
      acc_d = acc_q + ACC_WIDTH'(addend);
    end
  end

  // v0 marks the cycle in which popped data is on the FIFO output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      d1_q  <= '0;
      acc_q <= '0;
    end else begin
      v0_q  <= in_valid_i;
      v1_q  <= v0_q;
      if (v0_q) begin
        d1_q <= data_i;
      end
      acc_q <= acc_d;
    end
  end

  assign acc_o       = acc_q;
  assign pipe_busy_o = v0_q | v1_q;

endmodule

// File: rtl/vctr_sq_accum.sv
// Drains one vector from the upstream result FIFO on its done edge and returns the
// sum or sum of squares through a valid/ready result port.
module vctr_sq_accum import hsid_vctr_pkg::*; #(
  parameter int unsigned  DATA_WIDTH    = 16,
  parameter int unsigned  VECTOR_LENGTH = 8,
  localparam int unsigned ACC_WIDTH     = calc_acc_width(DATA_WIDTH, VECTOR_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sq_en,
  input  logic                  vctr_done,
  output logic                  vctr_rd_en,
  input  logic [DATA_WIDTH-1:0] vctr_data,
  output logic [ACC_WIDTH-1:0]  result_data,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  localparam int unsigned    CntW    = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(VECTOR_LENGTH - 1);

  acc_state_t             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   mode_q, mode_d;
  logic                   done_q;
  logic [ACC_WIDTH-1:0]   result_q, result_d;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   pipe_busy;
  logic                   trigger;
  logic                   clear;

  assign trigger = vctr_done & ~done_q;
  assign clear   = (state_q == IDLE) & trigger;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = DRAIN;
          cnt_d   = '0;
          mode_d  = sq_en;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!pipe_busy) begin
          state_d  = RESULT;
          result_d = acc;
        end
      end
      RESULT: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      done_q   <= vctr_done;
      result_q <= result_d;
    end
  end

  hsid_sq_acc_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (mode_q),
    .clear_i     (clear),
    .in_valid_i  (vctr_rd_en),
    .data_i      (vctr_data),
    .acc_o       (acc),
    .pipe_busy_o (pipe_busy)
  );

  assign vctr_rd_en   = (state_q == DRAIN);
  assign result_valid = (state_q == RESULT);
  assign busy         = (state_q != IDLE);
  assign result_data  = result_q;

endmodule
